// File: rtl/firehose_pkg.sv
// firehose_pkg
// Definitions shared by the firehose ADC-side blocks: the packer FSM state
// encoding, the packet size ceiling set by the downstream ping-pong buffer,
// and the sample/word widths.
package firehose_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2
    } packer_state_e;

    // Largest packet packet_streamer can buffer (one half of its ping-pong RAM).
    localparam int FIREHOSE_MAX_WORDS = 1024;

    localparam int SAMPLE_W = 8;
    localparam int WORD_W   = 2 * SAMPLE_W;
    localparam int SEQ_W    = 16;

    // Word counter only has to reach FIREHOSE_MAX_WORDS-1.
    localparam int WCNT_W   = $clog2(FIREHOSE_MAX_WORDS);

endpackage

// File: rtl/sample_packer_if.sv
// sample_packer_if
// Byte-in / word-out stream bundle around sample_packer.
//   in_valid          : in_sample is valid this cycle
//   in_sample         : one quantized sample, I in [7:4], Q in [3:0]
//   source_data       : packed 16-bit word towards packet_streamer
//   source_en         : one-cycle strobe, source_data valid
//   source_packet_end : qualifies source_en, last word of a packet
// Modports:
//   master : the side feeding samples and consuming words
//   slave  : sample_packer itself
interface sample_packer_if;
    import firehose_pkg::*;

    logic                  in_valid;
    logic [SAMPLE_W-1:0]   in_sample;
    logic [WORD_W-1:0]     source_data;
    logic                  source_en;
    logic                  source_packet_end;

    modport master (
        output in_valid,
        output in_sample,
        input  source_data,
        input  source_en,
        input  source_packet_end
    );

    modport slave (
        input  in_valid,
        input  in_sample,
        output source_data,
        output source_en,
        output source_packet_end
    );

endinterface

// File: rtl/sample_packer.sv
// sample_packer
// Packs the quantizer's byte stream into 16-bit words and frames them into
// WORDS_PER_PACKET-word packets for packet_streamer. Each packet starts with
// a 16-bit sequence-number header word; payload words carry two samples,
// the earlier one in [15:8]. No backpressure: downstream takes a word on
// any cycle.
// Ports:
//   clk        : ADC clock
//   reset      : synchronous, active-low
//   enable     : run request, looked at only at packet boundaries
//   sp         : sample_packer_if.slave (sample in, word out)
//   packet_seq : sequence number of the most recent header sent
//   busy       : a packet is in progress
// All outputs are registered.
module sample_packer
    import firehose_pkg::*;
#(
    parameter int WORDS_PER_PACKET = 512
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    sample_packer_if.slave       sp,
    output logic [SEQ_W-1:0]     packet_seq,
    output logic                 busy
);

    if (WORDS_PER_PACKET < 2 || WORDS_PER_PACKET > FIREHOSE_MAX_WORDS) begin : g_wpp_check
        $error("sample_packer: WORDS_PER_PACKET=%0d outside 2..%0d",
               WORDS_PER_PACKET, FIREHOSE_MAX_WORDS);
    end

    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS_PER_PACKET - 1);

    packer_state_e         state_q, state_d;
    logic                  phase_q, phase_d;
    logic [SAMPLE_W-1:0]   hi_q, hi_d;
    logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
    logic [SEQ_W-1:0]      seq_q, seq_d;
    logic [WORD_W-1:0]     source_data_q, source_data_d;
    logic                  source_en_q, source_en_d;
    logic                  source_packet_end_q, source_packet_end_d;
    logic [SEQ_W-1:0]      packet_seq_q, packet_seq_d;
    logic                  busy_q, busy_d;

    // A payload word completes on the second byte of a pair. Phase is 0
    // throughout HEADER, so a word can never complete there.
    logic word_done;
    logic last_word;

    assign word_done = (state_q == ST_PAYLOAD) && sp.in_valid && phase_q;
    assign last_word = (wcnt_q == LAST_WORD);

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (enable) state_d = ST_HEADER;
            ST_HEADER:  state_d = ST_PAYLOAD;
            ST_PAYLOAD: begin
                // enable only matters on the closing word of a packet
                if (word_done && last_word) begin
                    state_d = enable ? ST_HEADER : ST_IDLE;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // ---- output / datapath logic ----
    always_comb begin
        phase_d             = phase_q;
        hi_d                = hi_q;
        wcnt_d              = wcnt_q;
        seq_d               = seq_q;
        source_data_d       = source_data_q;
        source_en_d         = 1'b0;
        source_packet_end_d = 1'b0;
        packet_seq_d        = packet_seq_q;
        busy_d              = (state_d != ST_IDLE);

        if (state_q == ST_HEADER) begin
            source_data_d = seq_q;
            source_en_d   = 1'b1;
            packet_seq_d  = seq_q;
            wcnt_d        = WCNT_W'(1);
        end

        // Bytes are accepted in HEADER as well as PAYLOAD so a sample that
        // arrives while the header goes out is not lost; IDLE drops them.
        if (state_q != ST_IDLE && sp.in_valid) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                hi_d = sp.in_sample;
            end
        end

        if (word_done) begin
            source_data_d = {hi_q, sp.in_sample};
            source_en_d   = 1'b1;
            if (last_word) begin
                source_packet_end_d = 1'b1;
                seq_d               = seq_q + SEQ_W'(1);
                wcnt_d              = '0;
            end else begin
                wcnt_d = wcnt_q + WCNT_W'(1);
            end
        end
    end

    // ---- registered outputs and packing state ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            phase_q             <= 1'b0;
            wcnt_q              <= '0;
            seq_q               <= '0;
            source_data_q       <= '0;
            source_en_q         <= 1'b0;
            source_packet_end_q <= 1'b0;
            packet_seq_q        <= '0;
            busy_q              <= 1'b0;
        end else begin
            phase_q             <= phase_d;
            wcnt_q              <= wcnt_d;
            seq_q               <= seq_d;
            source_data_q       <= source_data_d;
            source_en_q         <= source_en_d;
            source_packet_end_q <= source_packet_end_d;
            packet_seq_q        <= packet_seq_d;
            busy_q              <= busy_d;
        end
    end

    // Holding register is pure data: only read once phase says it was loaded.
    always_ff @(posedge clk) begin
        hi_q <= hi_d;
    end

    assign sp.source_data       = source_data_q;
    assign sp.source_en         = source_en_q;
    assign sp.source_packet_end = source_packet_end_q;
    assign packet_seq           = packet_seq_q;
    assign busy                 = busy_q;

endmodule

// File: tb/tb_sample_packer.sv
// tb_sample_packer
// Directed bench for sample_packer with WORDS_PER_PACKET=4. A monitor logs
// every source_en word (data, end flag, clock-edge index) and each scenario
// task checks the log and the status outputs against hand-computed values.
module tb_sample_packer;
    import firehose_pkg::*;

    localparam int WPP = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] packet_seq;
    logic        busy;

    sample_packer_if sp_if ();

    sample_packer #(.WORDS_PER_PACKET(WPP)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .sp         (sp_if),
        .packet_seq (packet_seq),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] wq[$];
    bit          eq[$];
    int          cq[$];

    always @(negedge clk) begin
        if (sp_if.source_en === 1'b1) begin
            wq.push_back(sp_if.source_data);
            eq.push_back(sp_if.source_packet_end);
            cq.push_back(cyc);
        end
    end

    task automatic clear_log();
        wq.delete();
        eq.delete();
        cq.delete();
    endtask

    task automatic step(input logic en, input logic v, input logic [7:0] s);
        enable            = en;
        sp_if.in_valid    = v;
        sp_if.in_sample   = s;
        @(posedge clk);
        #1;
    endtask

    // lets the monitor catch the word registered at the last edge
    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        reset = 1'b1;
        settle();
        clear_log();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(1'b1, 1'b1, 8'h5A);
        step(1'b1, 1'b1, 8'hA5);
        step(1'b1, 1'b1, 8'h3C);
        total++; if (sp_if.source_en !== 1'b0) begin bad++; $display("FAIL reset_en: got %b want 0", sp_if.source_en); end
        total++; if (sp_if.source_packet_end !== 1'b0) begin bad++; $display("FAIL reset_end: got %b want 0", sp_if.source_packet_end); end
        total++; if (sp_if.source_data !== 16'h0000) begin bad++; $display("FAIL reset_data: got %h want 0000", sp_if.source_data); end
        total++; if (packet_seq !== 16'h0000) begin bad++; $display("FAIL reset_seq: got %h want 0000", packet_seq); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 1'b1;
        settle();
        clear_log();
    endtask

    task automatic test_basic();
        logic [15:0] exp_w [8] = '{16'h0000, 16'h0102, 16'h0304, 16'h0506,
                                   16'h0001, 16'h0708, 16'h090A, 16'h0B0C};
        bit          exp_e [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        int          exp_d [4] = '{1, 2, 2, 1};
        do_reset();
        step(1'b1, 1'b0, 8'h00);
        for (int b = 1; b <= 6; b++) step(1'b1, 1'b1, 8'(b));
        step(1'b0, 1'b0, 8'h00);   // second header goes out at this edge
        total++; if (packet_seq !== 16'h0001) begin bad++; $display("FAIL basic_pkt_seq: got %h want 0001", packet_seq); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
        for (int b = 7; b <= 12; b++) step(1'b0, 1'b1, 8'(b));
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle: got busy=%b want 0", busy); end
        step(1'b0, 1'b0, 8'h00);
        settle();
        total++; if (wq.size() !== 8) begin bad++; $display("FAIL basic_count: got %0d words want 8", wq.size()); end
        for (int i = 0; i < 8; i++) begin
            total++; if (wq[i] !== exp_w[i]) begin bad++; $display("FAIL basic_word%0d: got %h want %h", i, wq[i], exp_w[i]); end
            total++; if (eq[i] !== exp_e[i]) begin bad++; $display("FAIL basic_end%0d: got %b want %b", i, eq[i], exp_e[i]); end
        end
        for (int i = 0; i < 4; i++) begin
            total++; if (cq[i+1] - cq[i] !== exp_d[i]) begin bad++; $display("FAIL basic_gap%0d: got %0d want %0d", i, cq[i+1] - cq[i], exp_d[i]); end
        end
    endtask

    task automatic test_gap();
        int bb_edge;
        do_reset();
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'hAA);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'hBB);
        bb_edge = cyc;
        step(1'b0, 1'b0, 8'h00);
        settle();
        total++; if (wq.size() !== 2) begin bad++; $display("FAIL gap_count: got %0d words want 2", wq.size()); end
        total++; if (wq[1] !== 16'hAABB) begin bad++; $display("FAIL gap_word: got %h want aabb", wq[1]); end
        total++; if (cq[1] !== bb_edge) begin bad++; $display("FAIL gap_latency: got edge %0d want %0d", cq[1], bb_edge); end
    endtask

    task automatic test_enable_drop();
        do_reset();
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'hA1);
        for (int b = 2; b <= 6; b++) step(1'b0, 1'b1, 8'hA0 + 8'(b));
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_busy_end: got %b want 0", busy); end
        step(1'b0, 1'b1, 8'hC7);
        step(1'b0, 1'b0, 8'h00);
        settle();
        total++; if (wq.size() !== 4) begin bad++; $display("FAIL drop_count: got %0d words want 4", wq.size()); end
        total++; if (wq[3] !== 16'hA5A6) begin bad++; $display("FAIL drop_last: got %h want a5a6", wq[3]); end
        total++; if (eq[3] !== 1'b1) begin bad++; $display("FAIL drop_end: got %b want 1", eq[3]); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_busy: got %b want 0", busy); end
        total++; if (packet_seq !== 16'h0000) begin bad++; $display("FAIL drop_pkt_seq: got %h want 0000", packet_seq); end
    endtask

    task automatic test_reset_mid();
        int ends;
        do_reset();
        step(1'b1, 1'b0, 8'h00);
        for (int b = 1; b <= 6; b++) step(1'b1, 1'b1, 8'(b));
        step(1'b1, 1'b1, 8'h01);   // header 0001
        step(1'b1, 1'b1, 8'h02);   // word 0102
        reset = 1'b0;
        step(1'b1, 1'b1, 8'h03);
        total++; if (sp_if.source_en !== 1'b0) begin bad++; $display("FAIL rmid_en: got %b want 0", sp_if.source_en); end
        total++; if (sp_if.source_packet_end !== 1'b0) begin bad++; $display("FAIL rmid_end: got %b want 0", sp_if.source_packet_end); end
        total++; if (sp_if.source_data !== 16'h0000) begin bad++; $display("FAIL rmid_data: got %h want 0000", sp_if.source_data); end
        total++; if (packet_seq !== 16'h0000) begin bad++; $display("FAIL rmid_seq: got %h want 0000", packet_seq); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
        reset = 1'b1;
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        settle();
        ends = 0;
        foreach (eq[i]) ends += int'(eq[i]);
        total++; if (wq.size() !== 7) begin bad++; $display("FAIL rmid_count: got %0d words want 7", wq.size()); end
        total++; if (wq[5] !== 16'h0102) begin bad++; $display("FAIL rmid_last_before: got %h want 0102", wq[5]); end
        total++; if (ends !== 1) begin bad++; $display("FAIL rmid_ends: got %0d want 1", ends); end
        total++; if (wq[6] !== 16'h0000) begin bad++; $display("FAIL rmid_header: got %h want 0000", wq[6]); end
    endtask

    task automatic test_idle_discard();
        do_reset();
        step(1'b0, 1'b1, 8'h11);
        step(1'b0, 1'b1, 8'h22);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h33);
        step(1'b0, 1'b1, 8'h44);
        settle();
        total++; if (wq.size() !== 2) begin bad++; $display("FAIL discard_count: got %0d words want 2", wq.size()); end
        total++; if (wq[0] !== 16'h0000) begin bad++; $display("FAIL discard_header: got %h want 0000", wq[0]); end
        total++; if (wq[1] !== 16'h3344) begin bad++; $display("FAIL discard_word: got %h want 3344", wq[1]); end
    endtask

    // Walking 65536 packets to reach the wrap is too long, so the sequence
    // counter is preset to FFFF while idle.
    task automatic test_wrap();
        do_reset();
        force dut.seq_q = 16'hFFFF;
        step(1'b0, 1'b0, 8'h00);
        release dut.seq_q;
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h01);
        total++; if (packet_seq !== 16'hFFFF) begin bad++; $display("FAIL wrap_pkt_seq_ffff: got %h want ffff", packet_seq); end
        for (int b = 2; b <= 6; b++) step(1'b1, 1'b1, 8'(b));
        step(1'b0, 1'b0, 8'h00);
        settle();
        total++; if (wq[0] !== 16'hFFFF) begin bad++; $display("FAIL wrap_header_ffff: got %h want ffff", wq[0]); end
        total++; if (wq[4] !== 16'h0000) begin bad++; $display("FAIL wrap_header_0000: got %h want 0000", wq[4]); end
        total++; if (cq[4] - cq[3] !== 1) begin bad++; $display("FAIL wrap_b2b_gap: got %0d want 1", cq[4] - cq[3]); end
        total++; if (packet_seq !== 16'h0000) begin bad++; $display("FAIL wrap_pkt_seq_0000: got %h want 0000", packet_seq); end
    endtask

    initial begin
        reset           = 1'b0;
        enable          = 1'b0;
        sp_if.in_valid  = 1'b0;
        sp_if.in_sample = 8'h00;
        test_reset();
        test_basic();
        test_gap();
        test_enable_drop();
        test_reset_mid();
        test_idle_discard();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sample_packer.md
# sample_packer

Packs the quantizer's byte-wide sample stream into 16-bit words and frames them into fixed-length packets for `packet_streamer`. It sits directly upstream of `packet_streamer` in the ADC clock domain and drives its `source_data` / `source_en` / `source_packet_end` inputs. Each packet starts with a 16-bit sequence-number word. Packets always start and end on whole words.

## Interface
- `WORDS_PER_PACKET`, default 512: words per packet, header word included. Legal range 2..1024, limited by the downstream 1024-word ping-pong buffer.
- `clk`  in  1: ADC clock; the block's only clock.
- `reset`  in  1: synchronous, active-low reset.
- `enable`  in  1: run request; sampled only at packet boundaries.
- `in_valid`  in  1: `in_sample` is valid this cycle.
- `in_sample`  in  8: one quantized sample, I in [7:4], Q in [3:0].
- `source_data`  out  16: packed word to `packet_streamer`.
- `source_en`  out  1: one-cycle strobe, `source_data` valid.
- `source_packet_end`  out  1: qualifies `source_en`; marks the last word of a packet.
- `packet_seq`  out  16: sequence number of the most recent header sent.
- `busy`  out  1: high while a packet is in progress.

## Operation
- States:
  - IDLE: nothing in progress.
  - HEADER: one cycle; the sequence-number word is emitted.
  - PAYLOAD: samples are packed into words.
- IDLE → HEADER on the first cycle with `enable`=1.
- HEADER:
  - drives `source_data`=`seq`, `source_en`=1 and `packet_seq`←`seq`.
  - sets word count ←1, then goes to PAYLOAD.
- PAYLOAD:
  - a byte phase bit toggles on each `in_valid`.
  - phase 0 byte goes to holding register `hi`.
  - phase 1 byte: emit {`hi`, `in_sample`}, so the first sample lands in [15:8]; increment word count.
- Last word: when the emitted word is number WORDS_PER_PACKET-1, also assert `source_packet_end`, increment `seq` (16-bit, wraps FFFF→0000) and clear word count.
  - if `enable`=1 in that cycle: next state HEADER (back-to-back packet).
  - otherwise: next state IDLE.
- `enable` deasserted mid-packet has no effect; the current packet completes.
- `in_valid` in HEADER or IDLE:
  - HEADER: the byte is accepted into the phase logic and counts toward the payload.
  - IDLE: the byte is discarded; phase stays 0.
- The phase is always 0 at a packet boundary, because every packet carries an even number of payload bytes.
- No backpressure. The downstream block accepts a word every cycle.
- `busy` = (state != IDLE).
- Reset (low) at any time:
  - state ← IDLE; phase, word count and `seq` ← 0.
  - `source_en`, `source_packet_end` and `busy` ← 0; `source_data` and `packet_seq` ← 0.
  - a partial packet is abandoned, with no `source_packet_end`.

## Timing
- All outputs are registered.
- Header word:
  - `source_en` is high in the cycle after the cycle in which the state register becomes HEADER, i.e. 2 clk after `enable` is first seen in IDLE.
  - Exactly 1 cycle wide.
- Payload word: `source_en` is high 1 cycle after the clock edge that samples the phase-1 `in_valid` byte.
- Consecutive `source_en` pulses are at least 1 cycle apart during payload; with `in_valid` held at 1 they are exactly 2 cycles apart.
- Back-to-back packets: the header of packet n+1 follows the last word of packet n by 1 cycle.
- Word count needs 10 bits; the compare is against WORDS_PER_PACKET-1.

## Structure
- Shared package (`firehose_pkg`) holds:
  - the 2-bit state encoding (IDLE=0, HEADER=1, PAYLOAD=2);
  - `FIREHOSE_MAX_WORDS`=1024;
  - `SAMPLE_W`=8.
- Add a parameter range check on WORDS_PER_PACKET against `FIREHOSE_MAX_WORDS` (elaboration-time assertion).
- One module; no sub-module is warranted.

## Test plan
- WORDS_PER_PACKET=4, `enable`=1, `in_valid` held at 1 with samples 01,02,03,04,05,06:
  - words 0000, 0102, 0304, 0506; the last word carries `source_packet_end`.
  - next header 0001 one cycle after the last word.
- `in_valid` toggling 1,0,0,1 on samples AA, BB → single word AABB, `source_en` 1 cycle after the BB edge.
- `enable` dropped after the header of a 4-word packet → the packet completes, then state is IDLE, `busy`=0 and `packet_seq`=0000.
- 65537 packets of 2 words → `seq` wraps; the header after FFFF is 0000.
- Reset low mid-payload after word 0102:
  - all outputs 0 the next cycle, no `source_packet_end`.
  - after release the first header is 0000.
- `in_valid` samples 11, 22 in IDLE with `enable`=0, then `enable`=1 → the discarded bytes never appear; the first payload word comes from the next two samples.
